// File: rtl/mem_uart_if.sv
// mem_uart_if: soc external memory bus (mem_valid/mem_ready handshake).
interface mem_uart_if;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;

   modport master (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/mem_uart.sv
// mem_uart: memory-mapped 8N1 UART with TX holding stage, RX FIFO and a
// programmable bit divisor. Registers: DATA (0x0), STAT (0x4), DIV (0x8), reserved (0xC).
module mem_uart #(
   parameter logic [15:0] BASE_HI     = 16'h0201,
   parameter logic [15:0] DEFAULT_DIV = 16'd104,
   parameter int          RX_DEPTH    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   mem_uart_if.slave  bus,
   output logic       uart_tx,
   input  logic       uart_rx,
   output logic       irq
);

   localparam int PTR_W = $clog2(RX_DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rx_state_t;

   // Bus-side registers
   logic        ready_q, ready_d;
   logic [31:0] rdata_q, rdata_d;
   logic [15:0] div_q, div_d;
   logic        overrun_q, overrun_d;
   logic        frame_err_q, frame_err_d;

   // Transmitter
   tx_state_t   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [15:0] tx_div_q, tx_div_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic        uart_tx_q, uart_tx_d;

   // Receiver
   logic [2:0]  rx_sync_q, rx_sync_d;
   rx_state_t   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [15:0] rx_div_q, rx_div_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic [2:0]  rx_bit_q, rx_bit_d;

   // RX FIFO
   logic [7:0]     fifo_q [RX_DEPTH];
   logic [7:0]     fifo_d [RX_DEPTH];
   logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0] rd_ptr_q, rd_ptr_d;

   // Combinational control
   logic        hit, is_wr, tx_busy, tx_hold, accept, wr_en, rd_en;
   logic [1:0]  reg_sel;
   logic        tx_load, pop;
   logic        fifo_empty, fifo_full;
   logic        rx_bit, rx_fall, rx_push, frame_set, overrun_set;
   logic        tx_last, rx_last;
   logic [15:0] rx_half, div_merged;
   logic        unused_bits;

   assign unused_bits = ^{bus.mem_wdata[31:16], bus.mem_addr[15:4], bus.mem_addr[1:0]};

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

   // Address decode and acceptance; a DATA write is held off while the shifter is busy
   always_comb begin
      hit     = bus.mem_valid && !ready_q && (bus.mem_addr[31:16] == BASE_HI);
      reg_sel = bus.mem_addr[3:2];
      is_wr   = |bus.mem_wstrb;
      tx_busy = (tx_state_q != TX_IDLE);
      tx_hold = hit && is_wr && (reg_sel == 2'd0) && bus.mem_wstrb[0] && tx_busy;
      accept  = hit && !tx_hold;
      wr_en   = accept && is_wr;
      rd_en   = accept && !is_wr;
      tx_load = wr_en && (reg_sel == 2'd0) && bus.mem_wstrb[0];
      pop     = rd_en && (reg_sel == 2'd0) && !fifo_empty;
   end

   // Register file: read mux, DIV update with clamp, sticky flags where set beats clear
   always_comb begin
      ready_d     = accept;
      rdata_d     = '0;
      div_d       = div_q;
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;
      div_merged  = div_q;

      if (rd_en) begin
         case (reg_sel)
            2'd0: rdata_d[7:0] = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q[PTR_W-1:0]];
            2'd1: rdata_d[3:0] = {frame_err_q, overrun_q, !fifo_empty, tx_busy};
            2'd2: rdata_d[15:0] = div_q;
            default: rdata_d = '0;
         endcase
      end

      if (wr_en && (reg_sel == 2'd2)) begin
         if (bus.mem_wstrb[0]) div_merged[7:0]  = bus.mem_wdata[7:0];
         if (bus.mem_wstrb[1]) div_merged[15:8] = bus.mem_wdata[15:8];
         div_d = (div_merged < 16'd2) ? 16'd2 : div_merged;
      end

      if (wr_en && (reg_sel == 2'd1) && bus.mem_wstrb[0]) begin
         if (bus.mem_wdata[2]) overrun_d   = 1'b0;
         if (bus.mem_wdata[3]) frame_err_d = 1'b0;
      end
      if (overrun_set) overrun_d   = 1'b1;
      if (frame_set)   frame_err_d = 1'b1;
   end

   // TX next-state: each frame slot lasts tx_div cycles, data goes out LSB first
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_div_d   = tx_div_q;
      tx_shift_d = tx_shift_q;
      tx_bit_d   = tx_bit_q;
      tx_last    = (tx_cnt_q == (tx_div_q - 16'd1));

      case (tx_state_q)
         TX_IDLE: begin
            if (tx_load) begin
               tx_state_d = TX_START;
               tx_cnt_d   = '0;
               tx_div_d   = div_q;
               tx_shift_d = bus.mem_wdata[7:0];
               tx_bit_d   = '0;
            end
         end
         TX_START: begin
            if (tx_last) begin
               tx_state_d = TX_DATA;
               tx_cnt_d   = '0;
            end else begin
               tx_cnt_d = tx_cnt_q + 16'd1;
            end
         end
         TX_DATA: begin
            if (tx_last) begin
               tx_cnt_d   = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
            end else begin
               tx_cnt_d = tx_cnt_q + 16'd1;
            end
         end
         TX_STOP: begin
            if (tx_last) begin
               tx_state_d = TX_IDLE;
               tx_cnt_d   = '0;
            end else begin
               tx_cnt_d = tx_cnt_q + 16'd1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase

      case (tx_state_q)
         TX_START: uart_tx_d = 1'b0;
         TX_DATA:  uart_tx_d = tx_shift_q[0];
         default:  uart_tx_d = 1'b1;
      endcase
   end

   // RX next-state: start bit re-checked at DIV/2, later bits sampled every DIV cycles
   always_comb begin
      rx_sync_d  = {rx_sync_q[1:0], uart_rx};
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_div_d   = rx_div_q;
      rx_shift_d = rx_shift_q;
      rx_bit_d   = rx_bit_q;
      rx_push    = 1'b0;
      frame_set  = 1'b0;
      rx_bit     = rx_sync_q[1];
      rx_fall    = rx_sync_q[2] && !rx_sync_q[1];
      rx_half    = {1'b0, rx_div_q[15:1]};
      rx_last    = (rx_cnt_q == (rx_div_q - 16'd1));

      case (rx_state_q)
         RX_IDLE: begin
            if (rx_fall) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
               rx_div_d   = div_q;
            end
         end
         RX_START: begin
            if (rx_cnt_q == (rx_half - 16'd1)) begin
               rx_cnt_d = '0;
               rx_bit_d = '0;
               rx_state_d = rx_bit ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 16'd1;
            end
         end
         RX_DATA: begin
            if (rx_last) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_bit, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end else begin
               rx_cnt_d = rx_cnt_q + 16'd1;
            end
         end
         RX_STOP: begin
            if (rx_last) begin
               rx_cnt_d = '0;
               if (rx_bit) begin
                  rx_push    = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  frame_set  = 1'b1;
                  rx_state_d = RX_BREAK;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + 16'd1;
            end
         end
         RX_BREAK: begin
            if (rx_bit) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // FIFO pointers and storage; a pop in the same cycle frees room for a push into a full FIFO
   always_comb begin
      fifo_d      = fifo_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overrun_set = 1'b0;

      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

      if (rx_push) begin
         if (!fifo_full || pop) begin
            fifo_d[wr_ptr_q[PTR_W-1:0]] = rx_shift_q;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            overrun_set = 1'b1;
         end
      end
   end

   // State registers; reset aborts any frame in progress and idles the line high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q     <= 1'b0;
         rdata_q     <= '0;
         div_q       <= DEFAULT_DIV;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         tx_state_q  <= TX_IDLE;
         tx_cnt_q    <= '0;
         tx_div_q    <= DEFAULT_DIV;
         tx_shift_q  <= '0;
         tx_bit_q    <= '0;
         uart_tx_q   <= 1'b1;
         rx_sync_q   <= 3'b111;
         rx_state_q  <= RX_IDLE;
         rx_cnt_q    <= '0;
         rx_div_q    <= DEFAULT_DIV;
         rx_shift_q  <= '0;
         rx_bit_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         for (int i = 0; i < RX_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         ready_q     <= ready_d;
         rdata_q     <= rdata_d;
         div_q       <= div_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_div_q    <= tx_div_d;
         tx_shift_q  <= tx_shift_d;
         tx_bit_q    <= tx_bit_d;
         uart_tx_q   <= uart_tx_d;
         rx_sync_q   <= rx_sync_d;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_div_q    <= rx_div_d;
         rx_shift_q  <= rx_shift_d;
         rx_bit_q    <= rx_bit_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         for (int i = 0; i < RX_DEPTH; i++) fifo_q[i] <= fifo_d[i];
      end
   end

   assign bus.mem_ready = ready_q;
   assign bus.mem_rdata = rdata_q;
   assign uart_tx       = uart_tx_q;
   assign irq           = !fifo_empty;

endmodule

// File: tb/tb_mem_uart.sv
// tb_mem_uart: randomized bench for mem_uart with a queue-based model of the
// RX FIFO/flags and a line decoder for the transmitter.
module tb_mem_uart;

   localparam logic [31:0] A_DATA = 32'h0201_0000;
   localparam logic [31:0] A_STAT = 32'h0201_0004;
   localparam logic [31:0] A_DIV  = 32'h0201_0008;
   localparam logic [31:0] A_RSV  = 32'h0201_000C;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic uart_rx = 1'b1;
   logic uart_tx;
   logic irq;

   mem_uart_if bus();

   mem_uart #(
      .BASE_HI(16'h0201),
      .DEFAULT_DIV(16'd104),
      .RX_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .uart_tx(uart_tx),
      .uart_rx(uart_rx),
      .irq(irq)
   );

   always #5 clk = ~clk;

   int assertCount = 0;
   int failCount = 0;
   int cycleNum = 0;
   int lastAck = 0;
   int tbDiv = 104;
   bit monEn = 1'b1;

   logic [7:0] lineQ[$];
   logic [7:0] txExpQ[$];
   logic [7:0] rxModelQ[$];
   bit modelOverrun = 1'b0;
   bit modelFrameErr = 1'b0;

   always @(posedge clk) cycleNum++;

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // One bus transfer; waits a bounded time for mem_ready
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, output logic [31:0] rdata);
      int waited;
      bit gotReady;
      waited = 0;
      gotReady = 1'b0;
      rdata = '0;
      @(negedge clk);
      bus.mem_valid = 1'b1;
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
      bus.mem_wstrb = wstrb;
      while (!gotReady && waited < 2000) begin
         @(posedge clk);
         #1;
         waited++;
         if (bus.mem_ready) begin
            gotReady = 1'b1;
            rdata = bus.mem_rdata;
            lastAck = cycleNum;
         end
      end
      bus.mem_valid = 1'b0;
      bus.mem_wstrb = 4'h0;
      if (!gotReady) checkOutput("bus_timeout", {31'b0, gotReady}, 32'd1);
   endtask

   task automatic busWrite(input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] dummy;
      applyStimulus(addr, wdata, 4'hF, dummy);
   endtask

   task automatic busRead(input logic [31:0] addr, output logic [31:0] rdata);
      applyStimulus(addr, 32'h0, 4'h0, rdata);
   endtask

   task automatic setDiv(input int d);
      busWrite(A_DIV, d);
      tbDiv = (d < 2) ? 2 : d;
   endtask

   // Reference: value of the serial line in slot idx of an 8N1 frame
   function automatic logic lineBit(input logic [7:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return d[idx-1];
   endfunction

   function automatic logic [31:0] modelStat(input bit busy);
      return {28'b0, modelFrameErr, modelOverrun, rxModelQ.size() != 0, busy};
   endfunction

   // Reference RX behaviour: good frames enter a 4-entry queue or raise overrun
   task automatic modelRx(input logic [7:0] d, input bit stopBit);
      if (!stopBit) modelFrameErr = 1'b1;
      else if (rxModelQ.size() < 4) rxModelQ.push_back(d);
      else modelOverrun = 1'b1;
   endtask

   task automatic sendRxFrame(input logic [7:0] d, input bit stopBit);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         uart_rx = (i == 0) ? 1'b0 : (i == 9) ? stopBit : d[i-1];
         repeat (tbDiv) @(negedge clk);
      end
      uart_rx = 1'b1;
      repeat (tbDiv + 6) @(negedge clk);
      modelRx(d, stopBit);
   endtask

   task automatic checkDataRead(input string tag);
      logic [31:0] r;
      logic [31:0] exp;
      exp = (rxModelQ.size() != 0) ? {24'b0, rxModelQ.pop_front()} : 32'h0;
      busRead(A_DATA, r);
      checkOutput(tag, r, exp);
   endtask

   task automatic checkStat(input string tag, input bit busy);
      logic [31:0] r;
      busRead(A_STAT, r);
      checkOutput(tag, r, modelStat(busy));
   endtask

   task automatic checkLine(input string tag);
      logic [7:0] exp;
      checkOutput({tag, "_count"}, lineQ.size(), txExpQ.size());
      while (txExpQ.size() != 0 && lineQ.size() != 0) begin
         exp = txExpQ.pop_front();
         checkOutput(tag, {24'b0, lineQ.pop_front()}, {24'b0, exp});
      end
      lineQ.delete();
      txExpQ.delete();
   endtask

   // Line decoder: recovers bytes from uart_tx using the current divisor
   initial begin : lineMonitor
      logic prevTx;
      logic [7:0] b;
      prevTx = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (monEn && prevTx && !uart_tx) begin
            repeat (tbDiv / 2) @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
               repeat (tbDiv) @(posedge clk);
               #1;
               b[i] = uart_tx;
            end
            repeat (tbDiv) @(posedge clk);
            #1;
            lineQ.push_back(b);
         end
         prevTx = uart_tx;
      end
   end

   initial begin : mainSeq
      logic [31:0] r;
      logic [7:0] bt;
      int ack1, ack2, n, readyPulses;

      bus.mem_valid = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_wstrb = 4'h0;

      // Reset values
      repeat (5) @(posedge clk);
      #1;
      checkOutput("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
      checkOutput("rst_irq", {31'b0, irq}, 32'd0);
      checkOutput("rst_ready", {31'b0, bus.mem_ready}, 32'd0);
      checkOutput("rst_rdata", bus.mem_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      checkStat("rst_stat", 1'b0);
      busRead(A_DIV, r);
      checkOutput("rst_div", r, 32'd104);
      busWrite(A_RSV, 32'hFFFF_FFFF);
      busRead(A_RSV, r);
      checkOutput("rsv_read", r, 32'd0);

      // Out-of-window address gets no response
      readyPulses = 0;
      @(negedge clk);
      bus.mem_valid = 1'b1;
      bus.mem_addr  = 32'h0202_0000;
      bus.mem_wstrb = 4'h0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (bus.mem_ready) readyPulses++;
      end
      bus.mem_valid = 1'b0;
      checkOutput("no_decode", readyPulses, 0);

      // DIV clamp boundaries
      busWrite(A_DIV, 32'd0);
      busRead(A_DIV, r);
      checkOutput("div_clamp0", r, 32'd2);
      busWrite(A_DIV, 32'd1);
      busRead(A_DIV, r);
      checkOutput("div_clamp1", r, 32'd2);
      setDiv(4);
      busRead(A_DIV, r);
      checkOutput("div_4", r, 32'd4);

      // Exact TX waveform for 0xA5 at DIV=4
      busWrite(A_DATA, 32'hA5);
      txExpQ.push_back(8'hA5);
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("tx_a5_slot%0d", k), {31'b0, uart_tx}, {31'b0, lineBit(8'hA5, k / 4)});
      end
      repeat (20) @(posedge clk);
      checkStat("tx_idle_stat", 1'b0);

      // tx_busy while a random byte shifts out
      bt = 8'($urandom);
      busWrite(A_DATA, {24'b0, bt});
      txExpQ.push_back(bt);
      checkStat("tx_busy_stat", 1'b1);
      repeat (50) @(posedge clk);
      checkStat("tx_done_stat", 1'b0);

      // Back-to-back writes: second ack only after the first frame ends
      busWrite(A_DATA, 32'h11);
      ack1 = lastAck;
      busWrite(A_DATA, 32'h22);
      ack2 = lastAck;
      txExpQ.push_back(8'h11);
      txExpQ.push_back(8'h22);
      checkOutput("b2b_gap_min", {31'b0, (ack2 - ack1) >= 40}, 32'd1);
      checkOutput("b2b_gap_max", {31'b0, (ack2 - ack1) <= 44}, 32'd1);
      repeat (60) @(posedge clk);
      checkLine("tx_line");

      // Random TX bytes at random divisors
      for (int i = 0; i < 3; i++) begin
         setDiv($urandom_range(4, 9));
         bt = 8'($urandom);
         busWrite(A_DATA, {24'b0, bt});
         txExpQ.push_back(bt);
         repeat (12 * tbDiv) @(posedge clk);
      end
      checkLine("tx_rand");

      // Single RX frame 0x3C
      setDiv(4);
      sendRxFrame(8'h3C, 1'b1);
      checkOutput("rx_irq_set", {31'b0, irq}, 32'd1);
      checkStat("rx_stat_valid", 1'b0);
      checkDataRead("rx_3c");
      checkOutput("rx_irq_clr", {31'b0, irq}, 32'd0);
      checkStat("rx_stat_empty", 1'b0);

      // Five frames without reads: overrun, then drain and W1C
      for (int i = 1; i <= 5; i++) sendRxFrame(8'(i), 1'b1);
      checkStat("ovr_stat", 1'b0);
      for (int i = 0; i < 5; i++) checkDataRead($sformatf("ovr_read%0d", i));
      busWrite(A_STAT, 32'h4);
      modelOverrun = 1'b0;
      checkStat("ovr_w1c", 1'b0);

      // Start-bit glitch is ignored
      @(negedge clk);
      uart_rx = 1'b0;
      @(negedge clk);
      uart_rx = 1'b1;
      repeat (60) @(negedge clk);
      checkOutput("glitch_irq", {31'b0, irq}, 32'd0);
      checkStat("glitch_stat", 1'b0);

      // Framing error leaves the FIFO untouched
      sendRxFrame(8'h5A, 1'b1);
      sendRxFrame(8'h77, 1'b0);
      checkStat("ferr_stat", 1'b0);
      checkDataRead("ferr_read0");
      checkDataRead("ferr_read1");
      busWrite(A_STAT, 32'h8);
      modelFrameErr = 1'b0;
      checkStat("ferr_w1c", 1'b0);

      // Random RX bursts at random divisors
      for (int it = 0; it < 5; it++) begin
         setDiv($urandom_range(4, 10));
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) sendRxFrame(8'($urandom), 1'b1);
         checkOutput($sformatf("rand_irq%0d", it), {31'b0, irq}, {31'b0, rxModelQ.size() != 0});
         checkStat($sformatf("rand_stat%0d", it), 1'b0);
         while (rxModelQ.size() != 0) checkDataRead($sformatf("rand_read%0d", it));
         checkDataRead($sformatf("rand_empty%0d", it));
         busWrite(A_STAT, 32'hC);
         modelOverrun = 1'b0;
         modelFrameErr = 1'b0;
      end

      // Reset in the middle of a transmission
      setDiv(8);
      monEn = 1'b0;
      busWrite(A_DATA, 32'h00);
      repeat (12) @(posedge clk);
      #1;
      checkOutput("midtx_low", {31'b0, uart_tx}, 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midtx_rst_tx", {31'b0, uart_tx}, 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      checkStat("midtx_stat", 1'b0);
      busRead(A_DIV, r);
      checkOutput("midtx_div", r, 32'd104);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
